// File: rtl/conv_acc_multilane_if.sv
// Handshake and data bundle for the multi-lane windowed accumulator.
// The master drives the beats and accepts results; the slave is the accumulator.
interface conv_acc_multilane_if #(
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 5
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*IN_WIDTH-1:0]    in_data;
  logic [CNT_WIDTH-1:0]         cfg_len;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES*ACC_WIDTH-1:0]   out_data;
  logic [LANES-1:0]             out_sat;
  logic                         busy;

  modport master (
    output in_valid, in_data, cfg_len, flush, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  in_valid, in_data, cfg_len, flush, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/conv_acc_multilane.sv
// Multi-lane windowed accumulator: sums cfg_len signed terms per lane per window,
// with per-step saturation or wrap and a valid/ready result port.
module conv_acc_multilane #(
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 5,
  parameter int SATURATE  = 1
) (
  input logic                 clk,
  input logic                 rst,
  conv_acc_multilane_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                          state;
  logic [LANES-1:0][ACC_WIDTH-1:0] acc;
  logic [LANES-1:0]                sat;
  logic [CNT_WIDTH-1:0]            cnt;
  logic [CNT_WIDTH-1:0]            len_r;
  logic [CNT_WIDTH-1:0]            len_first;
  logic [LANES-1:0][ACC_WIDTH-1:0] acc_first;
  logic [LANES-1:0][ACC_WIDTH-1:0] acc_step;
  logic [LANES-1:0]                ovf_step;
  logic [ACC_WIDTH:0]              first_ext;
  logic [ACC_WIDTH:0]              step_ext;
  logic                            beat;
  logic                            start;
  logic                            last_beat;

  function automatic logic [ACC_WIDTH:0] add_ext(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [IN_WIDTH-1:0]  x);
    return {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-IN_WIDTH){x[IN_WIDTH-1]}}, x};
  endfunction

  // Returns {overflow, next accumulator value}; overflow shows as a sign-bit split.
  function automatic logic [ACC_WIDTH:0] step_lane(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [IN_WIDTH-1:0]  x);
    logic [ACC_WIDTH:0] s;
    s = add_ext(a, x);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      if (SATURATE != 32'sd0) return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
      else                    return {1'b1, s[ACC_WIDTH-1:0]};
    end else begin
      return {1'b0, s[ACC_WIDTH-1:0]};
    end
  endfunction

  assign bus.in_ready  = !bus.flush && ((state != OUT) || bus.out_ready);
  assign beat          = bus.in_valid && bus.in_ready;
  assign start         = beat && ((state == IDLE) || (state == OUT));
  assign last_beat     = (cnt + CNT_WIDTH'(1'b1)) == len_r;
  assign len_first     = (bus.cfg_len == '0) ? CNT_WIDTH'(1'b1) : bus.cfg_len;
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = acc;
  assign bus.out_sat   = sat;
  assign bus.busy      = (state != IDLE);

  // Per-lane first-beat load value and accumulate step with overflow flag.
  always_comb begin
    acc_first = '0;
    acc_step  = '0;
    ovf_step  = '0;
    first_ext = '0;
    step_ext  = '0;
    for (int k = 0; k < LANES; k++) begin
      first_ext    = add_ext({ACC_WIDTH{1'b0}}, bus.in_data[k*IN_WIDTH +: IN_WIDTH]);
      step_ext     = step_lane(acc[k], bus.in_data[k*IN_WIDTH +: IN_WIDTH]);
      acc_first[k] = first_ext[ACC_WIDTH-1:0];
      acc_step[k]  = step_ext[ACC_WIDTH-1:0];
      ovf_step[k]  = step_ext[ACC_WIDTH];
    end
  end

  // Window FSM and accumulator state; flush outranks everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sat   <= '0;
      cnt   <= '0;
      len_r <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      acc   <= '0;
      sat   <= '0;
      cnt   <= '0;
    end else if (start) begin
      len_r <= len_first;
      acc   <= acc_first;
      sat   <= '0;
      cnt   <= CNT_WIDTH'(1'b1);
      state <= (len_first == CNT_WIDTH'(1'b1)) ? OUT : ACC;
    end else begin
      case (state)
        ACC: begin
          if (beat) begin
            acc <= acc_step;
            sat <= sat | ovf_step;
            cnt <= cnt + CNT_WIDTH'(1'b1);
            if (last_beat) state <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) state <= IDLE;
        end
        IDLE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_acc_multilane.sv
// Scoreboard bench: three accumulator variants (20-bit saturating, 17-bit saturating,
// 17-bit wrapping) driven by the same stimulus and checked against a behavioural model.
module tb_conv_acc_multilane;
  localparam int M_IDLE = 0, M_ACC = 1, M_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [63:0] in_data;
  logic [4:0]  cfg_len;

  always #5 clk = ~clk;

  conv_acc_multilane_if #(.LANES(4), .IN_WIDTH(16), .ACC_WIDTH(20), .CNT_WIDTH(5)) b0 ();
  conv_acc_multilane_if #(.LANES(4), .IN_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(5)) b1 ();
  conv_acc_multilane_if #(.LANES(4), .IN_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(5)) b2 ();

  assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;  assign b2.in_valid = in_valid;
  assign b0.in_data  = in_data;   assign b1.in_data  = in_data;   assign b2.in_data  = in_data;
  assign b0.cfg_len  = cfg_len;   assign b1.cfg_len  = cfg_len;   assign b2.cfg_len  = cfg_len;
  assign b0.flush    = flush;     assign b1.flush    = flush;     assign b2.flush    = flush;
  assign b0.out_ready = out_ready; assign b1.out_ready = out_ready; assign b2.out_ready = out_ready;

  conv_acc_multilane #(.LANES(4), .IN_WIDTH(16), .ACC_WIDTH(20), .CNT_WIDTH(5), .SATURATE(1))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  conv_acc_multilane #(.LANES(4), .IN_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(5), .SATURATE(1))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  conv_acc_multilane #(.LANES(4), .IN_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(5), .SATURATE(0))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct packed {
    logic [79:0] d0;
    logic [67:0] d1;
    logic [67:0] d2;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic [3:0]  s2;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     m_st  = M_IDLE;
  int     m_cnt = 0;
  int     m_len = 0;
  longint m_acc[3][4];
  bit     m_sat[3][4];
  int     wid[3]  = '{20, 17, 17};
  bit     satv[3] = '{1'b1, 1'b1, 1'b0};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint lane_in(input int k);
    logic signed [15:0] t;
    t = in_data[k*16 +: 16];
    return longint'(t);
  endfunction

  function automatic longint madd(input longint a, input longint x, input int w, input bit s,
                                  output bit ovf);
    longint sum, md, mx, mn;
    md  = 64'sd1 <<< w;
    mx  = (md >>> 1) - 64'sd1;
    mn  = -(md >>> 1);
    sum = a + x;
    ovf = (sum > mx) || (sum < mn);
    if (!ovf) return sum;
    if (s) return (sum > mx) ? mx : mn;
    sum = sum & (md - 64'sd1);
    if (sum > mx) sum = sum - md;
    return sum;
  endfunction

  task automatic m_finish();
    exp_t        e;
    logic [63:0] t;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      t = m_acc[0][k]; e.d0[k*20 +: 20] = t[19:0];
      t = m_acc[1][k]; e.d1[k*17 +: 17] = t[16:0];
      t = m_acc[2][k]; e.d2[k*17 +: 17] = t[16:0];
      e.s0[k] = m_sat[0][k]; e.s1[k] = m_sat[1][k]; e.s2[k] = m_sat[2][k];
    end
    q.push_back(e);
    m_st = M_OUT;
  endtask

  task automatic m_first();
    m_len = (cfg_len == 5'd0) ? 1 : int'(cfg_len);
    m_cnt = 1;
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < 4; k++) begin
        m_acc[v][k] = lane_in(k);
        m_sat[v][k] = 1'b0;
      end
    if (m_len == 1) m_finish();
    else            m_st = M_ACC;
  endtask

  task automatic m_add();
    bit o;
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < 4; k++) begin
        m_acc[v][k] = madd(m_acc[v][k], lane_in(k), wid[v], satv[v], o);
        if (o) m_sat[v][k] = 1'b1;
      end
    m_cnt++;
    if (m_cnt == m_len) m_finish();
  endtask

  task automatic m_clear();
    if (m_st == M_OUT && q.size() > 0) void'(q.pop_back());
    m_st  = M_IDLE;
    m_cnt = 0;
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < 4; k++) begin
        m_acc[v][k] = 0;
        m_sat[v][k] = 1'b0;
      end
  endtask

  // Called just after a falling edge with inputs set; checks, advances the model, waits one cycle.
  task automatic cycle();
    logic exp_rdy;
    bit   acc_beat;
    exp_t e;
    #1;
    exp_rdy = !flush && (m_st != M_OUT || out_ready);
    check_eq("in_ready", 128'({b0.in_ready, b1.in_ready, b2.in_ready}), 128'({3{exp_rdy}}));
    check_eq("out_valid", 128'({b0.out_valid, b1.out_valid, b2.out_valid}), 128'({3{m_st == M_OUT}}));
    check_eq("busy", 128'({b0.busy, b1.busy, b2.busy}), 128'({3{m_st != M_IDLE}}));
    if (m_st == M_OUT) begin
      check_eq("sb_size", 128'(q.size()), 128'(1));
      if (q.size() > 0) begin
        e = q[0];
        check_eq("out_data_v0", 128'(b0.out_data), 128'(e.d0));
        check_eq("out_data_v1", 128'(b1.out_data), 128'(e.d1));
        check_eq("out_data_v2", 128'(b2.out_data), 128'(e.d2));
        check_eq("out_sat", 128'({b0.out_sat, b1.out_sat, b2.out_sat}), 128'({e.s0, e.s1, e.s2}));
        if (out_ready && !flush) void'(q.pop_front());
      end
    end
    acc_beat = in_valid && exp_rdy;
    if (flush) m_clear();
    else begin
      case (m_st)
        M_IDLE: if (acc_beat) m_first();
        M_ACC:  if (acc_beat) m_add();
        M_OUT:  if (out_ready) begin
                  if (acc_beat) m_first();
                  else          m_st = M_IDLE;
                end
        default: m_st = M_IDLE;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input bit v, input int a0, input int a1, input int a2, input int a3);
    in_valid = v;
    in_data  = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    cycle();
  endtask

  task automatic idle();
    beat(1'b0, 0, 0, 0, 0);
  endtask

  // Reset is raised between clock edges to exercise its asynchronous path.
  task automatic pulse_rst();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_valid", 128'({b0.out_valid, b1.out_valid, b2.out_valid}), 128'(0));
    check_eq("rst_busy", 128'({b0.busy, b1.busy, b2.busy}), 128'(0));
    check_eq("rst_data", 128'(b0.out_data), 128'(0));
    check_eq("rst_sat", 128'({b0.out_sat, b1.out_sat, b2.out_sat}), 128'(0));
    m_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_len = 5'd3; flush = 1'b0; out_ready = 1'b1;
    m_clear();
    repeat (2) @(negedge clk);
    check_eq("reset_valid", 128'({b0.out_valid, b1.out_valid, b2.out_valid}), 128'(0));
    check_eq("reset_busy", 128'({b0.busy, b1.busy, b2.busy}), 128'(0));
    check_eq("reset_data", 128'({b0.out_data, b1.out_data}), 128'(0));
    check_eq("reset_sat", 128'({b0.out_sat, b1.out_sat, b2.out_sat}), 128'(0));
    rst = 1'b0;
    idle();

    // Basic three-term window
    cfg_len = 5'd3;
    beat(1'b1, 10, 100, -1, 0);
    beat(1'b1, -4, 200, -2, 5);
    beat(1'b1, 7, 300, -3, -5);
    check_eq("dflt_lane0", 128'(b0.out_data[19:0]), 128'(20'd13));
    check_eq("dflt_sat", 128'(b0.out_sat), 128'(4'd0));
    idle();
    idle();

    // Back-to-back two-term windows
    cfg_len = 5'd2;
    repeat (6) beat(1'b1, 1, 1, 1, 1);
    idle();

    // Backpressure on a pending result
    beat(1'b1, 3, 4, 5, 6);
    beat(1'b1, 1, 1, 1, 1);
    out_ready = 1'b0;
    repeat (5) beat(1'b1, 9, 9, 9, 9);
    out_ready = 1'b1;
    beat(1'b1, 9, 9, 9, 9);
    beat(1'b1, 2, 2, 2, 2);
    idle();

    // Overflow: clamp vs wrap on lane1, then recovery from a clamped value
    cfg_len = 5'd4;
    repeat (4) beat(1'b1, 5, 32767, -3, -100);
    check_eq("sat_lane1", 128'(b1.out_data[33:17]), 128'(17'd65535));
    check_eq("wrap_lane1", 128'(b2.out_data[33:17]), 128'(17'h1FFFC));
    check_eq("sat_flag1", 128'({b0.out_sat[1], b1.out_sat[1], b2.out_sat[1]}), 128'(3'b011));
    check_eq("sat_other", 128'({b1.out_sat[0], b1.out_sat[2], b1.out_sat[3]}), 128'(3'b000));
    idle();
    cfg_len = 5'd6;
    repeat (4) beat(1'b1, 32767, 0, 0, -32768);
    repeat (2) beat(1'b1, -32768, 0, 0, -32768);
    check_eq("sat_recover", 128'(b1.out_data[16:0]), 128'(17'h1FFFF));
    idle();

    // Zero and one length windows, and a mid-window length change
    cfg_len = 5'd0;
    beat(1'b1, -7, 8, -9, 10);
    beat(1'b1, 32767, -32768, 1, -1);
    cfg_len = 5'd1;
    beat(1'b1, -32768, 32767, 0, 2);
    idle();
    cfg_len = 5'd3;
    beat(1'b1, 1, 2, 3, 4);
    cfg_len = 5'd5;
    beat(1'b1, 1, 2, 3, 4);
    beat(1'b1, 1, 2, 3, 4);
    check_eq("len_hold", 128'(b0.out_valid), 128'(1'b1));
    idle();

    // Flush part-way through a window, then on a pending result
    cfg_len = 5'd4;
    beat(1'b1, 50, 50, 50, 50);
    beat(1'b1, 50, 50, 50, 50);
    flush = 1'b1;
    beat(1'b1, 50, 50, 50, 50);
    flush = 1'b0;
    cfg_len = 5'd2;
    beat(1'b1, 1, 2, 3, 4);
    beat(1'b1, 1, 1, 1, 1);
    check_eq("post_flush_lane0", 128'(b0.out_data[19:0]), 128'(20'd2));
    idle();
    cfg_len = 5'd1;
    out_ready = 1'b0;
    beat(1'b1, 77, 77, 77, 77);
    flush = 1'b1;
    idle();
    flush = 1'b0;
    out_ready = 1'b1;
    idle();

    // Asynchronous reset mid-window
    cfg_len = 5'd4;
    beat(1'b1, 1000, 1000, 1000, 1000);
    beat(1'b1, 1000, 1000, 1000, 1000);
    pulse_rst();
    cfg_len = 5'd2;
    beat(1'b1, 5, 5, 5, 5);
    beat(1'b1, -2, -2, -2, -2);
    check_eq("post_rst_lane3", 128'(b0.out_data[79:60]), 128'(20'd3));
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cfg_len   = 5'($urandom_range(0, 6));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      if (flush && m_st == M_OUT) out_ready = 1'b0;
      beat($urandom_range(0, 3) != 0, rnd16(), rnd16(), rnd16(), rnd16());
    end
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) idle();
    check_eq("sb_drain", 128'(q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
